// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic             imem_req_valid;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_req_ready;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head is visible combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output T                           o_head,
    output logic [cntWidth(DEPTH)-1:0] o_count
);

    localparam int CW = cntWidth(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_doPop  = i_pop && !i_clear && (r_count != '0);
    assign w_doPush = i_push && !i_clear && ((r_count != CW'(DEPTH)) || w_doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: in-order imem requests, prefetch buffer, stale-response dropping on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [WIDTH-1:0]  PCTargetE,
    fetch_unit_if.master      imem,
    output logic [WIDTH-1:0]  PCF,
    output logic [WIDTH-1:0]  instrF,
    output logic [WIDTH-1:0]  PCPlus4F,
    output logic              validF
);

    localparam int CW = cntWidth(DEPTH);
    localparam int SW = CW + 2;

    logic [WIDTH-1:0] r_fpc;
    logic [CW-1:0]    r_outst;
    logic [CW-1:0]    r_drop;

    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_pcqCount;
    logic [CW-1:0]    w_inFlight;
    logic [SW-1:0]    w_inUse;
    logic [WIDTH-1:0] w_pcqHead;
    fetch_entry_t     w_head;
    fetch_entry_t     w_pushEntry;
    logic             w_empty;
    logic             w_reqValid;
    logic             w_reqFire;
    logic             w_rspLive;
    logic             w_rspStale;
    logic             w_pop;

    // Every in-flight request, live or stale, reserves a FIFO slot so a response is never refused.
    assign w_inUse    = SW'(r_outst) + SW'(r_drop) + SW'(w_count);
    assign w_inFlight = r_outst + r_drop;
    assign w_reqValid = !flush && (w_inUse < SW'(DEPTH));
    assign w_reqFire  = w_reqValid && imem.imem_req_ready;
    assign w_rspStale = imem.imem_rsp_valid && !flush && (r_drop != '0);
    assign w_rspLive  = imem.imem_rsp_valid && !flush && (r_drop == '0) && (w_pcqCount != '0);
    assign w_empty    = (w_count == '0);
    assign w_pop      = !w_empty && !stall && !flush;

    assign imem.imem_req_valid = w_reqValid;
    assign imem.imem_req_addr  = r_fpc;
    assign w_pushEntry         = '{pc: w_pcqHead, instr: imem.imem_rsp_data};

    // Redirect converts everything in flight into drops; a response landing this cycle is one of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc   <= RESET_PC;
            r_outst <= '0;
            r_drop  <= '0;
        end else if (flush) begin
            r_fpc   <= PCTargetE;
            r_outst <= '0;
            r_drop  <= (imem.imem_rsp_valid && (w_inFlight != '0)) ? w_inFlight - 1'b1 : w_inFlight;
        end else begin
            if (w_reqFire) r_fpc <= r_fpc + WIDTH'(4);
            if (w_rspStale) r_drop <= r_drop - 1'b1;
            case ({w_reqFire, w_rspLive})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_prefetch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rspLive),
        .i_data  (w_pushEntry),
        .i_pop   (w_pop),
        .i_clear (flush),
        .o_head  (w_head),
        .o_count (w_count)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [WIDTH-1:0])
    ) u_pcQueue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_reqFire),
        .i_data  (r_fpc),
        .i_pop   (w_rspLive),
        .i_clear (flush),
        .o_head  (w_pcqHead),
        .o_count (w_pcqCount)
    );

    assign validF   = !w_empty;
    assign PCF      = w_empty ? '0 : w_head.pc;
    assign instrF   = w_empty ? NOP_INSTR : w_head.instr;
    assign PCPlus4F = w_empty ? '0 : w_head.pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with variable latency and a PC-stream scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] PCF;
    logic [31:0] instrF;
    logic [31:0] PCPlus4F;
    logic        validF;

    fetch_unit_if #(.WIDTH(32)) imemIf ();

    fetch_unit #(
        .WIDTH    (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .PCTargetE (PCTargetE),
        .imem      (imemIf.master),
        .PCF       (PCF),
        .instrF    (instrF),
        .PCPlus4F  (PCPlus4F),
        .validF    (validF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     memQ[$];
    logic [31:0] expQ[$];
    logic [31:0] expReqAddr = RESET_PC;
    int          cyc = 0;
    int          lastDue = 0;
    int          checks = 0;
    int          failures = 0;
    bit          flushPrev = 0;
    int          idle = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One bench cycle: drive controls, let memory answer, then log any accepted request.
    task automatic applyStimulus(input logic s, input logic f, input logic [31:0] tgt,
                                 input logic rdy, input int kLo, input int kHi);
        int due;
        @(negedge clk);
        cyc++;
        stall = s;
        flush = f;
        PCTargetE = tgt;
        imemIf.imem_req_ready = rdy;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            imemIf.imem_rsp_valid = 1'b1;
            imemIf.imem_rsp_data  = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end else begin
            imemIf.imem_rsp_valid = 1'b0;
            imemIf.imem_rsp_data  = $urandom;
        end
        #1;
        if (imemIf.imem_req_valid && imemIf.imem_req_ready) begin
            checkOutput("reqAddr", imemIf.imem_req_addr, expReqAddr);
            due = cyc + $urandom_range(kHi, kLo);
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back('{addr: imemIf.imem_req_addr, due: due});
            expReqAddr = expReqAddr + 32'd4;
            checkOutput("inFlightLimit", 32'(memQ.size() <= DEPTH), 32'd1);
        end
        if (f) expReqAddr = tgt;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        imemIf.imem_req_ready = 1'b1;
        imemIf.imem_rsp_valid = 1'b0;
        #1;
        checkOutput("resetValid", 32'(validF), 32'd0);
        checkOutput("resetInstr", instrF, NOP_INSTR);
        checkOutput("resetPCF", PCF, 32'd0);
        checkOutput("resetPCPlus4", PCPlus4F, 32'd0);
        checkOutput("resetReqValid", 32'(imemIf.imem_req_valid), 32'd1);
        checkOutput("resetReqAddr", imemIf.imem_req_addr, RESET_PC);
        memQ.delete();
        lastDue = cyc;
        expReqAddr = RESET_PC;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: expected PC stream advances on consumption and restarts at every redirect.
    initial begin
        logic [31:0] pc;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                expQ.delete();
                expQ.push_back(RESET_PC);
                flushPrev = 0;
                idle = 0;
                continue;
            end
            if (flushPrev) checkOutput("validAfterFlush", 32'(validF), 32'd0);
            if (flush) checkOutput("noReqOnFlush", 32'(imemIf.imem_req_valid), 32'd0);
            if (validF) begin
                checkOutput("PCF", PCF, expQ[0]);
                checkOutput("instrF", instrF, memWord(expQ[0]));
                checkOutput("PCPlus4F", PCPlus4F, expQ[0] + 32'd4);
                idle = 0;
            end else begin
                checkOutput("bubbleInstr", instrF, NOP_INSTR);
                checkOutput("bubblePCF", PCF, 32'd0);
                checkOutput("bubblePCPlus4", PCPlus4F, 32'd0);
                idle++;
                if (idle > 60) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL fetchProgress actual=%0d idle cycles expected<=60", idle);
                    idle = 0;
                end
            end
            flushPrev = flush;
            if (flush) begin
                expQ.delete();
                expQ.push_back(PCTargetE);
                idle = 0;
            end else if (validF && !stall) begin
                pc = expQ.pop_front();
                expQ.push_back(pc + 32'd4);
            end
        end
    end

    initial begin
        logic [31:0] heldAddr;
        logic [31:0] tgt;
        imemIf.imem_req_ready = 1'b1;
        imemIf.imem_rsp_valid = 1'b0;
        imemIf.imem_rsp_data  = '0;

        doReset();
        repeat (12) applyStimulus(0, 0, 0, 1, 1, 1);

        repeat (3) applyStimulus(1, 0, 0, 1, 1, 1);
        repeat (6) applyStimulus(0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            if (i == 0) heldAddr = imemIf.imem_req_addr;
            else checkOutput("addrHoldNotReady", imemIf.imem_req_addr, heldAddr);
            if (i == 3) checkOutput("drainedValid", 32'(validF), 32'd0);
        end
        repeat (6) applyStimulus(0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 10 && memQ.size() < 2; i++) applyStimulus(0, 0, 0, 1, 3, 3);
        checkOutput("twoOutstanding", 32'(memQ.size()), 32'd2);
        applyStimulus(0, 1, 32'h0000_0100, 1, 3, 3);
        repeat (12) applyStimulus(0, 0, 0, 1, 3, 3);

        repeat (4) applyStimulus(1, 0, 0, 1, 1, 1);
        applyStimulus(1, 1, 32'h0000_0200, 1, 1, 1);
        repeat (8) applyStimulus(0, 0, 0, 1, 1, 2);

        applyStimulus(0, 1, 32'hFFFF_FFF4, 1, 1, 1);
        repeat (10) applyStimulus(0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 500; i++) begin
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2))
                                           : ($urandom & 32'hFFFF_FFFC);
            applyStimulus($urandom_range(3) == 0, $urandom_range(19) == 0, tgt,
                          $urandom_range(3) != 0, 1, 4);
        end

        repeat (3) applyStimulus(0, 0, 0, 1, 2, 3);
        doReset();
        repeat (30) applyStimulus($urandom_range(3) == 0, 1'b0, 0, $urandom_range(3) != 0, 1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
